// File: rtl/ascii_distance_rx_if.sv
// Serial line and decoded-telemetry signals of the distance link receiver.
// slave: the receiver (takes rx, drives results); master: the peer that
// drives the line and consumes the results.
interface ascii_distance_rx_if;
    logic        rx;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [15:0] value;
    logic        value_valid;
    logic        frame_err;
    logic        parse_err;

    modport slave (
        input  rx,
        output rx_byte, rx_byte_valid, value, value_valid, frame_err, parse_err
    );

    modport master (
        output rx,
        input  rx_byte, rx_byte_valid, value, value_valid, frame_err, parse_err
    );
endinterface

// File: rtl/ascii_distance_rx.sv
// UART 8N1 receiver plus line parser for the "DDDDD\r\n" distance stream.
//
// RX FSM
//   state   | meaning
//   R_IDLE  | wait for line idle-high (after reset), then for a start bit
//   R_START | half-bit delay, confirm start bit still low at mid-start
//   R_DATA  | sample 8 data bits at mid-bit, LSB first
//   R_STOP  | sample stop bit at mid-stop, accept byte or flag frame error
//
// Parser FSM
//   state   | meaning
//   P_SYNC  | drop bytes until LF (line boundary)
//   P_DIGIT | collect NUM_DIGITS decimal digits into acc
//   P_CR    | expect CR
//   P_LF    | expect LF, publish value if it fits 16 bits
module ascii_distance_rx #(
    parameter int CLK_HZ       = 12000000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int NUM_DIGITS   = 5
) (
    input  logic clk,
    input  logic rst_n,
    ascii_distance_rx_if.slave bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DCW   = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DCW-1:0]   DIG_LAST  = DCW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
    typedef enum logic [1:0] {P_SYNC, P_DIGIT, P_CR, P_LF} p_state_t;

    logic             rx_meta, rx_s;
    r_state_t         r_state, r_next;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_d;
    logic [7:0]       shift, shift_d;
    logic             armed, armed_d;
    logic             stop_ok, stop_bad;

    logic [7:0]       rx_byte_r;
    logic             rx_byte_valid_r;
    logic             frame_err_r;

    p_state_t         p_state, p_next;
    logic [16:0]      acc, acc_d, acc_x10;
    logic [DCW-1:0]   dcnt, dcnt_d;
    logic [15:0]      value_r, value_d;
    logic             value_valid_r, value_valid_d;
    logic             parse_err_r, parse_err_d;
    logic             is_digit, is_cr, is_lf;

    // Two-flop synchronizer for the asynchronous serial input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // RX next-state and bit-timing control. Until one full bit time of
    // idle-high has been seen, a low line is not taken as a start bit, so a
    // reset released mid-frame does not lock onto a data bit.
    always_comb begin
        r_next   = r_state;
        cnt_d    = cnt;
        bit_d    = bit_idx;
        shift_d  = shift;
        armed_d  = armed;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (!armed) begin
                    if (rx_s) begin
                        if (cnt == BIT_LAST) armed_d = 1'b1;
                        else                 cnt_d   = cnt + 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                end else if (!rx_s) begin
                    r_next = R_START;
                    cnt_d  = HALF_LAST;
                end
            end
            R_START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        r_next = R_DATA;
                        cnt_d  = BIT_LAST;
                        bit_d  = '0;
                    end else begin
                        r_next = R_IDLE;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            R_DATA: begin
                if (cnt == '0) begin
                    shift_d = {rx_s, shift[7:1]};
                    cnt_d   = BIT_LAST;
                    if (bit_idx == 3'd7) r_next = R_STOP;
                    else                 bit_d  = bit_idx + 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            R_STOP: begin
                if (cnt == '0) begin
                    r_next   = R_IDLE;
                    stop_ok  = rx_s;
                    stop_bad = !rx_s;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // RX datapath registers and byte/frame-error strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            bit_idx         <= '0;
            shift           <= '0;
            armed           <= 1'b0;
            rx_byte_r       <= '0;
            rx_byte_valid_r <= 1'b0;
            frame_err_r     <= 1'b0;
        end else begin
            cnt             <= cnt_d;
            bit_idx         <= bit_d;
            shift           <= shift_d;
            armed           <= armed_d;
            rx_byte_valid_r <= stop_ok;
            frame_err_r     <= stop_bad;
            if (stop_ok) rx_byte_r <= shift;
        end
    end

    assign is_digit = (rx_byte_r >= 8'h30) && (rx_byte_r <= 8'h39);
    assign is_cr    = (rx_byte_r == 8'h0D);
    assign is_lf    = (rx_byte_r == 8'h0A);
    assign acc_x10  = {acc[13:0], 3'b000} + {acc[15:0], 1'b0};

    // Parser state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_state <= P_SYNC;
        else        p_state <= p_next;
    end

    // Parser next-state, accumulator update and result strobes.
    always_comb begin
        p_next        = p_state;
        acc_d         = acc;
        dcnt_d        = dcnt;
        value_d       = value_r;
        value_valid_d = 1'b0;
        parse_err_d   = 1'b0;
        if (frame_err_r) begin
            p_next = P_SYNC;
            acc_d  = '0;
            dcnt_d = '0;
        end else if (rx_byte_valid_r) begin
            case (p_state)
                P_SYNC: begin
                    if (is_lf) begin
                        p_next = P_DIGIT;
                        acc_d  = '0;
                        dcnt_d = '0;
                    end
                end
                P_DIGIT: begin
                    if (is_digit) begin
                        acc_d = acc_x10 + {13'd0, rx_byte_r[3:0]};
                        if (dcnt == DIG_LAST) p_next = P_CR;
                        else                  dcnt_d = dcnt + 1'b1;
                    end else begin
                        parse_err_d = 1'b1;
                        acc_d       = '0;
                        dcnt_d      = '0;
                        p_next      = is_lf ? P_DIGIT : P_SYNC;
                    end
                end
                P_CR: begin
                    if (is_cr) begin
                        p_next = P_LF;
                    end else begin
                        parse_err_d = 1'b1;
                        acc_d       = '0;
                        dcnt_d      = '0;
                        p_next      = is_lf ? P_DIGIT : P_SYNC;
                    end
                end
                P_LF: begin
                    acc_d  = '0;
                    dcnt_d = '0;
                    if (is_lf) begin
                        p_next = P_DIGIT;
                        if (!acc[16]) begin
                            value_d       = acc[15:0];
                            value_valid_d = 1'b1;
                        end else begin
                            parse_err_d = 1'b1;
                        end
                    end else begin
                        parse_err_d = 1'b1;
                        p_next      = P_SYNC;
                    end
                end
                default: p_next = P_SYNC;
            endcase
        end
    end

    // Parser datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            dcnt          <= '0;
            value_r       <= '0;
            value_valid_r <= 1'b0;
            parse_err_r   <= 1'b0;
        end else begin
            acc           <= acc_d;
            dcnt          <= dcnt_d;
            value_r       <= value_d;
            value_valid_r <= value_valid_d;
            parse_err_r   <= parse_err_d;
        end
    end

    assign bus.rx_byte       = rx_byte_r;
    assign bus.rx_byte_valid = rx_byte_valid_r;
    assign bus.value         = value_r;
    assign bus.value_valid   = value_valid_r;
    assign bus.frame_err     = frame_err_r;
    assign bus.parse_err     = parse_err_r;

endmodule

// File: tb/tb_ascii_distance_rx.sv
// Bench for ascii_distance_rx: directed and random lines against a
// line-level reference model.
module tb_ascii_distance_rx;
    localparam int CPB = 16;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ascii_distance_rx_if bus();

    ascii_distance_rx #(
        .CLK_HZ(160000),
        .BAUD(10000),
        .NUM_DIGITS(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] got_bytes[$];
    int         got_values[$];
    int         got_perr = 0, got_ferr = 0, got_clash = 0;

    logic [7:0] exp_bytes[$];
    int         exp_values[$];
    int         exp_perr = 0, exp_ferr = 0;

    bit         m_synced = 1'b0;
    logic [7:0] m_seg[$];
    int         m_last_value = 0;

    // Observe strobes away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_byte_valid) got_bytes.push_back(bus.rx_byte);
            if (bus.value_valid)   got_values.push_back(int'(bus.value));
            if (bus.parse_err)     got_perr++;
            if (bus.frame_err)     got_ferr++;
            if (bus.frame_err && bus.parse_err)   got_clash++;
            if (bus.value_valid && bus.parse_err) got_clash++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: a line is the bytes between two LFs; once synced,
    // each line is either exactly five digits plus CR (value or overflow
    // error) or malformed (exactly one parse error).
    task automatic model_line();
        bit ok;
        int v;
        ok = (m_seg.size() == 6);
        v = 0;
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                if (m_seg[i] < 8'h30 || m_seg[i] > 8'h39) ok = 1'b0;
                else v = v * 10 + int'(m_seg[i] - 8'h30);
            end
            if (m_seg[5] != CR) ok = 1'b0;
        end
        if (!ok || v > 65535) begin
            exp_perr++;
        end else begin
            exp_values.push_back(v);
            m_last_value = v;
        end
    endtask

    task automatic model_feed(input logic [7:0] b);
        exp_bytes.push_back(b);
        if (b == LF) begin
            if (m_synced) model_line();
            m_synced = 1'b1;
            m_seg.delete();
        end else begin
            m_seg.push_back(b);
        end
    endtask

    task automatic model_frame_err();
        exp_ferr++;
        m_synced = 1'b0;
        m_seg.delete();
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (good_stop) begin
            bus.rx = 1'b1;
            repeat (CPB) @(negedge clk);
            model_feed(b);
        end else begin
            bus.rx = 1'b0;
            repeat (CPB / 2 + 3) @(negedge clk);
            bus.rx = 1'b1;
            repeat (CPB / 2 - 3) @(negedge clk);
            model_frame_err();
        end
    endtask

    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic send_random_line();
        logic [7:0] q[$];
        int kind, v, pos;
        kind = $urandom_range(0, 3);
        v = (kind == 1) ? $urandom_range(65536, 99999) : $urandom_range(0, 65535);
        for (int p = 10000; p >= 1; p = p / 10) q.push_back(8'(48 + (v / p) % 10));
        q.push_back(CR);
        q.push_back(LF);
        if (kind == 2) begin
            pos = $urandom_range(0, 5);
            q[pos] = 8'($urandom_range(65, 90));
        end else if (kind == 3) begin
            q.delete(5);
        end
        foreach (q[i]) begin
            send_byte(q[i], 1'b1);
            idle($urandom_range(0, 6));
        end
    endtask

    task automatic compare_step(input string tag);
        idle(3 * CPB);
        check({tag, ".nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            check($sformatf("%s.byte%0d", tag, i), got_bytes[i], exp_bytes[i]);
        check({tag, ".nvalues"}, got_values.size(), exp_values.size());
        for (int i = 0; i < got_values.size() && i < exp_values.size(); i++)
            check($sformatf("%s.value%0d", tag, i), got_values[i], exp_values[i]);
        check({tag, ".parse_err"}, got_perr, exp_perr);
        check({tag, ".frame_err"}, got_ferr, exp_ferr);
        check({tag, ".clash"}, got_clash, 0);
        check({tag, ".value_hold"}, bus.value, m_last_value);
        got_bytes.delete();  exp_bytes.delete();
        got_values.delete(); exp_values.delete();
        got_perr = 0; exp_perr = 0;
        got_ferr = 0; exp_ferr = 0;
        got_clash = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rx_byte"},       bus.rx_byte, 0);
        check({tag, ".rx_byte_valid"}, bus.rx_byte_valid, 0);
        check({tag, ".value"},         bus.value, 0);
        check({tag, ".value_valid"},   bus.value_valid, 0);
        check({tag, ".frame_err"},     bus.frame_err, 0);
        check({tag, ".parse_err"},     bus.parse_err, 0);
    endtask

    initial begin
        logic [7:0] b7;
        rst_n = 1'b0;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(3 * CPB);

        send_str("\n00057\r\n", 2);
        compare_step("first_line");

        send_str("65535\r\n70000\r\n", 3);
        compare_step("range");

        send_str("12a45\r\n00100\r\n", 1);
        compare_step("bad_digit");

        send_byte(8'h30, 1'b0);
        idle(2 * CPB);
        send_str("\n00042\r\n", 2);
        compare_step("frame_err");

        bus.rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(4 * CPB);
        bus.rx = 1'b0;
        repeat (7) @(negedge clk);
        idle(4 * CPB);
        compare_step("glitch");

        send_str("01234\r\n00999\r\n", 0);
        compare_step("back_to_back");

        for (int n = 0; n < 12; n++) send_random_line();
        compare_step("random");

        send_str("000", 1);
        b7 = 8'h37;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        bus.rx = b7[0];
        repeat (CPB) @(negedge clk);
        bus.rx = b7[1];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        bus.rx = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        repeat (4) @(negedge clk);
        check_reset_outputs("mid_reset_hold");
        rst_n = 1'b1;
        m_synced = 1'b0;
        m_seg.delete();
        m_last_value = 0;
        compare_step("after_abort");

        send_str("\n00077\r\n", 2);
        compare_step("resend");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
